// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for the memory_arbiter block: FSM encoding and the
// byte-address split into word address and byte offset.
package memory_arbiter_pkg;

  localparam int DATA_W     = 64;
  localparam int WORD_BYTES = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
    return byte_addr >> 3;
  endfunction

  function automatic logic [2:0] offset_of(input logic [31:0] byte_addr);
    return 3'(byte_addr & 32'h7);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and memory_ctrl bus of the arbiter. Directions are named from the
// arbiter's side; the slave modport is the arbiter, master is everything around it.
interface memory_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8
);
  localparam int BA_W = ADDR_WIDTH + 3;

  logic [NUM_REQ-1:0]      i_req;
  logic [NUM_REQ-1:0]      i_req_write;
  logic [NUM_REQ-1:0]      i_lock;
  logic [NUM_REQ*BA_W-1:0] i_req_addr;
  logic [NUM_REQ*64-1:0]   i_req_wdata;
  logic [NUM_REQ-1:0]      o_grant;
  logic [NUM_REQ-1:0]      o_ack;
  logic [NUM_REQ-1:0]      o_rdata_valid;
  logic [63:0]             o_rdata;
  logic [NUM_REQ-1:0]      o_error;

  logic                    o_mem_read_64;
  logic                    o_mem_write_64;
  logic [63:0]             o_mem_write_data;
  logic [ADDR_WIDTH-1:0]   o_mem_addr_hi;
  logic [2:0]              o_mem_addr_lo;
  logic                    i_mem_busy;
  logic                    i_mem_error;
  logic [63:0]             i_mem_data;

  modport slave (
    input  i_req, i_req_write, i_lock, i_req_addr, i_req_wdata,
    input  i_mem_busy, i_mem_error, i_mem_data,
    output o_grant, o_ack, o_rdata_valid, o_rdata, o_error,
    output o_mem_read_64, o_mem_write_64, o_mem_write_data, o_mem_addr_hi, o_mem_addr_lo
  );

  modport master (
    output i_req, i_req_write, i_lock, i_req_addr, i_req_wdata,
    output i_mem_busy, i_mem_error, i_mem_data,
    input  o_grant, o_ack, o_rdata_valid, o_rdata, o_error,
    input  o_mem_read_64, o_mem_write_64, o_mem_write_data, o_mem_addr_hi, o_mem_addr_lo
  );

endinterface

// File: rtl/memory_arbiter_rr.sv
// Combinational round-robin picker: first requesting index at or after ptr_i,
// wrapping modulo NUM_REQ. ptr_i must be below NUM_REQ.
module memory_arbiter_rr #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               any_o
);

  function automatic int wrap(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_o && req_i[wrap(int'(ptr_i) + k)]) begin
        win_o[wrap(int'(ptr_i) + k)] = 1'b1;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory_ctrl port between NUM_REQ requesters,
// with locked bursts bounded by MAX_BURST and read data/error routing.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic              i_clk,
  input  logic              i_areset_n,
  memory_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BA_W  = ADDR_WIDTH + 3;
  typedef logic [IDX_W-1:0] idx_t;

  arb_state_e           state_q, state_d;
  idx_t                 owner_q, owner_d;
  idx_t                 rr_ptr_q, rr_ptr_d;
  idx_t                 last_owner_q, last_owner_d;
  logic [7:0]           burst_cnt_q, burst_cnt_d;
  logic                 no_ack_q, no_ack_d;
  logic [NUM_REQ-1:0]   rvld_q, rvld_d;

  idx_t                 owner_inc, pick_ptr, win_idx;
  logic [NUM_REQ-1:0]   win_oh, own_oh;
  logic                 win_any;
  logic                 granted, own_req, own_wr, own_lock;
  logic                 rd_stb, wr_stb, ack, rel, arbitrate;
  logic [BA_W-1:0]      own_addr;
  logic [DATA_W-1:0]    own_wdata;

  assign owner_inc = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
  assign own_oh    = NUM_REQ'(1) << owner_q;

  always_comb begin
    granted   = (state_q == GRANT);
    own_req   = bus.i_req[owner_q];
    own_wr    = bus.i_req_write[owner_q];
    own_lock  = bus.i_lock[owner_q];
    own_addr  = bus.i_req_addr[int'(owner_q)*BA_W +: BA_W];
    own_wdata = bus.i_req_wdata[int'(owner_q)*DATA_W +: DATA_W];
    rd_stb    = granted & own_req & ~own_wr & ~bus.i_mem_busy;
    wr_stb    = granted & own_req &  own_wr & ~bus.i_mem_busy;
    ack       = rd_stb | wr_stb;
    // A locked owner that is merely idle keeps the grant; only an ack can end a lock.
    rel       = granted & (ack ? (~own_lock | (burst_cnt_q + 8'd1 == 8'(MAX_BURST)))
                               : (~own_req & ~own_lock));
    arbitrate = ~granted | rel;
    // The releasing edge already searches from owner+1 so alternating requesters hand off.
    pick_ptr  = rel ? owner_inc : rr_ptr_q;
  end

  memory_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i (bus.i_req),
    .ptr_i (pick_ptr),
    .win_o (win_oh),
    .any_o (win_any)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = idx_t'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    no_ack_d     = no_ack_q;
    rvld_d       = rd_stb ? own_oh : '0;
    if (ack) begin
      burst_cnt_d  = burst_cnt_q + 8'd1;
      last_owner_d = owner_q;
      no_ack_d     = 1'b0;
    end
    if (rel) rr_ptr_d = owner_inc;
    if (arbitrate) begin
      if (win_any) begin
        state_d     = GRANT;
        owner_d     = win_idx;
        burst_cnt_d = '0;
      end else begin
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      last_owner_q <= '0;
      burst_cnt_q  <= '0;
      no_ack_q     <= 1'b1;
      rvld_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      no_ack_q     <= no_ack_d;
      rvld_q       <= rvld_d;
    end
  end

  assign bus.o_grant          = granted ? own_oh : '0;
  assign bus.o_ack            = ack ? own_oh : '0;
  assign bus.o_mem_read_64    = rd_stb;
  assign bus.o_mem_write_64   = wr_stb;
  assign bus.o_mem_write_data = granted ? own_wdata : '0;
  assign bus.o_mem_addr_hi    = granted ? ADDR_WIDTH'(word_of(32'(own_addr))) : '0;
  assign bus.o_mem_addr_lo    = granted ? offset_of(32'(own_addr)) : '0;
  assign bus.o_rdata          = bus.i_mem_data;
  assign bus.o_rdata_valid    = rvld_q;
  assign bus.o_error          = (bus.i_mem_error & ~no_ack_q) ? (NUM_REQ'(1) << last_owner_q) : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (2 requesters, MAX_BURST=4) with a small
// byte-addressed memory model standing in for memory_ctrl.
module tb_memory_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(8)) bus ();

  memory_arbiter #(
    .NUM_REQ    (2),
    .ADDR_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .i_clk      (clk),
    .i_areset_n (rst_n),
    .bus        (bus)
  );

  // Memory model: init pattern on reset, one-cycle read latency, unaligned access.
  logic [7:0] mem [0:2047];

  function automatic logic [63:0] rd8(input int a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = mem[(a + i) % 2048];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'hF7 - 8'(i);
      bus.i_mem_data <= '0;
    end else begin
      if (bus.o_mem_read_64)
        bus.i_mem_data <= rd8(int'({bus.o_mem_addr_hi, bus.o_mem_addr_lo}));
      if (bus.o_mem_write_64)
        for (int i = 0; i < 8; i++)
          mem[(int'({bus.o_mem_addr_hi, bus.o_mem_addr_lo}) + i) % 2048] <= bus.o_mem_write_data[i*8 +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int r, input logic [10:0] a);
    bus.i_req_addr[r*11 +: 11] = a;
  endtask

  task automatic set_wdata(input int r, input logic [63:0] d);
    bus.i_req_wdata[r*64 +: 64] = d;
  endtask

  localparam logic [63:0] A_BASE = 64'hA0A0_1111_0000_0000;
  localparam logic [63:0] B_BASE = 64'hB0B0_2222_0000_0000;
  localparam logic [63:0] C_BASE = 64'hC0C0_3333_0000_0000;
  localparam logic [63:0] E1_W   = 64'hE1E1_4444_5555_6666;
  localparam logic [63:0] UNAL_W = 64'h0204_0068_30a8_dce1;

  initial begin
    rst_n           = 1'b0;
    bus.i_req       = '0;
    bus.i_req_write = '0;
    bus.i_lock      = '0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_mem_busy  = 1'b1;
    bus.i_mem_error = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(bus.o_grant), 64'h0);
    chk("rst_ack", 64'(bus.o_ack), 64'h0);
    chk("rst_rvld", 64'(bus.o_rdata_valid), 64'h0);
    chk("rst_strobes", 64'({bus.o_mem_read_64, bus.o_mem_write_64}), 64'h0);
    chk("rst_error", 64'(bus.o_error), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("err_before_ack", 64'(bus.o_error), 64'h0);
    bus.i_mem_error = 1'b0;

    // Post-reset init: both read while memory is busy.
    bus.i_req = 2'b11;
    set_addr(0, 11'h000);
    set_addr(1, 11'h008);
    #1;
    chk("init_idle_grant", 64'(bus.o_grant), 64'h0);
    step();
    chk("init_grant0", 64'(bus.o_grant), 64'h1);
    chk("init_busy_ack", 64'(bus.o_ack), 64'h0);
    step();
    chk("init_busy_ack2", 64'(bus.o_ack), 64'h0);
    bus.i_mem_busy = 1'b0;
    #1;
    chk("init_ack0", 64'(bus.o_ack), 64'h1);
    chk("init_rd_stb", 64'(bus.o_mem_read_64), 64'h1);
    step();
    bus.i_req[0] = 1'b0;
    #1;
    chk("init_ack1", 64'(bus.o_ack), 64'h2);
    chk("init_rvld0", 64'(bus.o_rdata_valid), 64'h1);
    chk("init_rdata0", bus.o_rdata, 64'hF0F1_F2F3_F4F5_F6F7);
    step();
    bus.i_req[1] = 1'b0;
    #1;
    chk("init_rvld1", 64'(bus.o_rdata_valid), 64'h2);
    chk("init_rdata1", bus.o_rdata, 64'hE8E9_EAEB_ECED_EEEF);
    chk("init_noack", 64'(bus.o_ack), 64'h0);
    step();
    chk("init_idle", 64'(bus.o_grant), 64'h0);

    // Unlocked contention: four writes each, acks alternate.
    bus.i_req_write = 2'b11;
    set_wdata(0, A_BASE);
    set_wdata(1, B_BASE);
    bus.i_req = 2'b11;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("rr_ack0", 64'(bus.o_ack), 64'h1);
      step();
      if (k == 3) bus.i_req[0] = 1'b0;
      else set_wdata(0, A_BASE + 64'(k + 1));
      #1;
      chk("rr_ack1", 64'(bus.o_ack), 64'h2);
      step();
      if (k == 3) bus.i_req[1] = 1'b0;
      else set_wdata(1, B_BASE + 64'(k + 1));
      #1;
    end
    chk("rr_tail_noack", 64'(bus.o_ack), 64'h0);
    step();
    bus.i_req_write = 2'b00;
    bus.i_req = 2'b11;
    step();
    chk("rb_ack0", 64'(bus.o_ack), 64'h1);
    step();
    bus.i_req[0] = 1'b0;
    #1;
    chk("rb_rvld0", 64'(bus.o_rdata_valid), 64'h1);
    chk("rb_data0", bus.o_rdata, A_BASE + 64'd3);
    step();
    bus.i_req[1] = 1'b0;
    #1;
    chk("rb_rvld1", 64'(bus.o_rdata_valid), 64'h2);
    chk("rb_data1", bus.o_rdata, B_BASE + 64'd3);
    step();

    // Locked burst bounded at 4, then handoff and resume.
    bus.i_req_write = 2'b11;
    bus.i_lock = 2'b01;
    set_addr(0, 11'h000);
    set_wdata(0, C_BASE);
    set_addr(1, 11'h030);
    set_wdata(1, E1_W);
    bus.i_req = 2'b11;
    step();
    for (int j = 0; j < 4; j++) begin
      chk("lock_ack0", 64'(bus.o_ack), 64'h1);
      step();
      set_addr(0, 11'((j + 1) * 8));
      set_wdata(0, C_BASE + 64'(j + 1));
      #1;
    end
    chk("lock_handoff", 64'(bus.o_ack), 64'h2);
    step();
    bus.i_req[1] = 1'b0;
    #1;
    chk("lock_resume", 64'(bus.o_ack), 64'h1);
    step();
    set_addr(0, 11'h028);
    set_wdata(0, C_BASE + 64'd5);
    #1;
    chk("lock_resume2", 64'(bus.o_ack), 64'h1);
    step();
    bus.i_req[0] = 1'b0;
    #1;
    chk("lock_hold_grant", 64'(bus.o_grant), 64'h1);
    chk("lock_hold_ack", 64'(bus.o_ack), 64'h0);
    step();
    chk("lock_hold_grant2", 64'(bus.o_grant), 64'h1);
    bus.i_lock = 2'b00;
    step();
    chk("lock_release", 64'(bus.o_grant), 64'h0);
    chk("mem_0x20", rd8(32'h20), C_BASE + 64'd4);
    chk("mem_0x30", rd8(32'h30), E1_W);

    // Unaligned write stalled by busy, then read back.
    bus.i_mem_busy = 1'b1;
    bus.i_req_write = 2'b10;
    set_addr(1, 11'h07e);
    set_wdata(1, UNAL_W);
    bus.i_req = 2'b10;
    step();
    chk("unal_grant", 64'(bus.o_grant), 64'h2);
    chk("unal_stall", 64'(bus.o_ack), 64'h0);
    step();
    chk("unal_stall2", 64'(bus.o_ack), 64'h0);
    bus.i_mem_busy = 1'b0;
    #1;
    chk("unal_wr_ack", 64'(bus.o_ack), 64'h2);
    chk("unal_wr_stb", 64'(bus.o_mem_write_64), 64'h1);
    chk("unal_addr_hi", 64'(bus.o_mem_addr_hi), 64'h0f);
    chk("unal_addr_lo", 64'(bus.o_mem_addr_lo), 64'h6);
    step();
    bus.i_req_write[1] = 1'b0;
    #1;
    chk("unal_rd_ack", 64'(bus.o_ack), 64'h2);
    chk("unal_rd_stb", 64'(bus.o_mem_read_64), 64'h1);
    step();
    bus.i_req[1] = 1'b0;
    #1;
    chk("unal_rvld", 64'(bus.o_rdata_valid), 64'h2);
    chk("unal_rdata", bus.o_rdata, UNAL_W);
    step();
    chk("unal_rvld_end", 64'(bus.o_rdata_valid), 64'h0);

    // Error routed to the last acked requester.
    bus.i_mem_error = 1'b1;
    #1;
    chk("err_route", 64'(bus.o_error), 64'h2);
    bus.i_mem_error = 1'b0;
    #1;
    chk("err_clear", 64'(bus.o_error), 64'h0);

    // Reset in the middle of a locked read burst by requester 1.
    bus.i_req_write = 2'b00;
    bus.i_lock = 2'b10;
    set_addr(0, 11'h040);
    set_addr(1, 11'h048);
    bus.i_req = 2'b11;
    step();
    chk("mid_ack0", 64'(bus.o_ack), 64'h1);
    step();
    bus.i_req[0] = 1'b0;
    #1;
    chk("mid_ack1", 64'(bus.o_ack), 64'h2);
    step();
    chk("mid_ack1b", 64'(bus.o_ack), 64'h2);
    chk("mid_rvld1", 64'(bus.o_rdata_valid), 64'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(bus.o_grant), 64'h0);
    chk("mid_rst_ack", 64'(bus.o_ack), 64'h0);
    chk("mid_rst_rvld", 64'(bus.o_rdata_valid), 64'h0);
    chk("mid_rst_strobes", 64'({bus.o_mem_read_64, bus.o_mem_write_64}), 64'h0);
    bus.i_lock = 2'b00;
    bus.i_req = 2'b11;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 64'(bus.o_grant), 64'h0);
    step();
    chk("post_rst_grant0", 64'(bus.o_grant), 64'h1);
    bus.i_req = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
